// File: rtl/pmem_access_ctrl.sv
// Program memory port arbiter: fetch reads pass through, byte-stream loader writes LE words.
// Latency: fetch response 1 cycle after grant; one write cycle per assembled word.
// Backpressure: load_byte_ready low during word write; fetch held ungranted while a load session runs.
module pmem_access_ctrl #(
    parameter int unsigned MEM_BYTES = 2048,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned LEN_W     = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_start,
    input  logic [LEN_W-1:0] load_len,
    input  logic [7:0]       load_byte,
    input  logic             load_byte_valid,
    output logic             load_byte_ready,
    output logic             load_busy,
    output logic             load_done,
    output logic             load_err,
    output logic             cpu_hold,
    input  logic             fetch_req,
    input  logic [31:0]      fetch_addr,
    output logic             fetch_gnt,
    output logic [31:0]      fetch_rdata,
    output logic             fetch_rvalid,
    output logic [31:0]      mem_addr,
    output logic             mem_we,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] widx_q, widx_d;
    logic [31:0]      buf_q, buf_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q;
    logic             rvalid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            widx_q   <= '0;
            buf_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            widx_q   <= widx_d;
            buf_q    <= buf_d;
            err_q    <= err_d;
            rvalid_q <= fetch_gnt;
            if (fetch_gnt) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        cnt_d           = cnt_q;
        widx_d          = widx_q;
        buf_d           = buf_q;
        err_d           = err_q;
        fetch_gnt       = 1'b0;
        load_byte_ready = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = fetch_addr;
        mem_wdata       = buf_q;

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    // A new session always clears the sticky error before judging its own length.
                    err_d  = 1'b0;
                    cnt_d  = '0;
                    widx_d = '0;
                    buf_d  = '0;
                    if (load_len == '0) begin
                        state_d = DONE;
                    end else if (32'(load_len) > MEM_BYTES) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        len_d   = load_len;
                        state_d = COLLECT;
                    end
                end else begin
                    fetch_gnt = fetch_req;
                end
            end
            COLLECT: begin
                load_byte_ready = 1'b1;
                if (load_byte_valid) begin
                    case (cnt_q[1:0])
                        2'd0:    buf_d[7:0]   = load_byte;
                        2'd1:    buf_d[15:8]  = load_byte;
                        2'd2:    buf_d[23:16] = load_byte;
                        default: buf_d[31:24] = load_byte;
                    endcase
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q[1:0] == 2'd3 || cnt_d == len_q) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                // Buffer is zeroed after every write, so a short final word is already padded.
                mem_we   = 1'b1;
                mem_addr = BASE_ADDR + 32'({widx_q, 2'b00});
                widx_d   = widx_q + LEN_W'(1);
                buf_d    = '0;
                state_d  = (cnt_q == len_q) ? DONE : COLLECT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign load_busy    = (state_q != IDLE);
    assign cpu_hold     = (state_q != IDLE);
    assign load_done    = (state_q == DONE);
    assign load_err     = err_q;
    assign fetch_rdata  = rdata_q;
    assign fetch_rvalid = rvalid_q;

endmodule
